// File: rtl/puzzle_alu_pkg.sv
// puzzle_alu_pkg: opcode map, FSM encoding and op-class helper for puzzle_alu_seq.
package puzzle_alu_pkg;

    localparam int unsigned OP_SET   = 0;
    localparam int unsigned OP_ADD   = 1;
    localparam int unsigned OP_SUB   = 2;
    localparam int unsigned OP_WRITE = 4;
    localparam int unsigned OP_MOD   = 5;
    localparam int unsigned OP_DIV   = 6;
    localparam int unsigned OP_CHECK = 7;
    localparam int unsigned OP_COPY  = 9;
    localparam int unsigned OP_INV   = 10;
    localparam int unsigned OP_AUP   = 11;
    localparam int unsigned OP_ADW   = 12;
    localparam int unsigned OP_LESS  = 13;
    localparam int unsigned OP_MDIST = 14;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXEC   = 3'd1;
    localparam logic [2:0] S_DIVLD  = 3'd2;
    localparam logic [2:0] S_DIVRUN = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    function automatic logic is_div_op(input int unsigned op);
        return (op == OP_DIV) || (op == OP_MOD) || (op == OP_AUP) ||
               (op == OP_ADW) || (op == OP_MDIST);
    endfunction

endpackage

// File: rtl/puzzle_alu_seq_divmod.sv
// puzzle_divmod: unsigned restoring divide by the constant SIDE,
// one quotient bit per clock, WIDTH clocks after load.
module puzzle_divmod #(
    parameter int WIDTH = 8,
    parameter int SIDE  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] SDIV = WIDTH'(SIDE);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Remainder stays below SIDE, so the low WIDTH bits of the trial
    // subtraction are exact whenever it is taken.
    always_comb begin
        sh   = {r_q, q_q[WIDTH-1]};
        ge   = (sh >= {1'b0, SDIV});
        diff = sh[WIDTH-1:0] - SDIV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            q_q   <= dividend;
            r_q   <= '0;
            cnt_q <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            q_q   <= {q_q[WIDTH-2:0], ge};
            r_q   <= ge ? diff : sh[WIDTH-1:0];
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign valid     = (cnt_q == '0);

endmodule

// File: rtl/puzzle_alu_seq.sv
// puzzle_alu_seq: registered start/done ALU for the SIDE x SIDE sliding puzzle.
// Optional carry/borrow flag output cf under PUZZLE_ALU_CARRY_EN.
module puzzle_alu_seq
    import puzzle_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIDE  = 3,
    parameter int OPW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
`ifdef PUZZLE_ALU_CARRY_EN
    output logic             cf,
`endif
    output logic             zf
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2:0]       state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zf_q, zf_d;
`ifdef PUZZLE_ALU_CARRY_EN
    logic             cf_q, cf_d;
    logic [WIDTH:0]   sum_w;
    assign sum_w = {1'b0, a_q} + {1'b0, b_q};
`endif

    logic [WIDTH-1:0] qa, ra, qb, rb, dq, dr;
    logic             va, vb, ld;

    assign ld = (state_q == S_DIVLD);

    puzzle_divmod #(.WIDTH(WIDTH), .SIDE(SIDE)) u_div_a (
        .clk(clk), .rst_n(rst_n), .load(ld), .dividend(a_q),
        .quotient(qa), .remainder(ra), .valid(va)
    );

    puzzle_divmod #(.WIDTH(WIDTH), .SIDE(SIDE)) u_div_b (
        .clk(clk), .rst_n(rst_n), .load(ld), .dividend(b_q),
        .quotient(qb), .remainder(rb), .valid(vb)
    );

    assign dq = (qa >= qb) ? qa - qb : qb - qa;
    assign dr = (ra >= rb) ? ra - rb : rb - ra;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        out_d   = out_q;
        zf_d    = zf_q;
`ifdef PUZZLE_ALU_CARRY_EN
        cf_d    = cf_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A start arriving while done is still high is dropped.
                if (start && !done_q) begin
                    op_d    = op;
                    a_d     = ina;
                    b_d     = inb;
                    state_d = is_div_op(32'(op)) ? S_DIVLD : S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OPW'(OP_SET),
                    OPW'(OP_WRITE): out_d = a_q;
                    OPW'(OP_COPY):  out_d = b_q;
                    OPW'(OP_ADD): begin
                        out_d = a_q + b_q;
`ifdef PUZZLE_ALU_CARRY_EN
                        cf_d  = sum_w[WIDTH];
`endif
                    end
                    OPW'(OP_SUB): begin
                        out_d = b_q - a_q;
`ifdef PUZZLE_ALU_CARRY_EN
                        cf_d  = (a_q > b_q);
`endif
                    end
                    OPW'(OP_INV):   out_d = (~b_q) + WIDTH'(1);
                    OPW'(OP_CHECK): zf_d  = (a_q == b_q);
                    OPW'(OP_LESS):  zf_d  = (a_q < b_q);
                    default: begin
                        out_d = '0;
                        zf_d  = 1'b0;
                    end
                endcase
            end
            S_DIVLD: begin
                state_d = S_DIVRUN;
                cnt_d   = CW'(WIDTH - 1);
            end
            S_DIVRUN: begin
                if (cnt_q == '0) state_d = S_FIN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_FIN: begin
                if (va && vb) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    case (op_q)
                        OPW'(OP_DIV): out_d = qb;
                        OPW'(OP_MOD): out_d = rb;
                        OPW'(OP_AUP): out_d = dq;
                        OPW'(OP_ADW): out_d = dr;
                        OPW'(OP_MDIST): out_d = dq + dr;
                        default:      out_d = '0;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
            zf_q    <= 1'b0;
`ifdef PUZZLE_ALU_CARRY_EN
            cf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            out_q   <= out_d;
            zf_q    <= zf_d;
`ifdef PUZZLE_ALU_CARRY_EN
            cf_q    <= cf_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign out  = out_q;
    assign zf   = zf_q;
`ifdef PUZZLE_ALU_CARRY_EN
    assign cf   = cf_q;
`endif

endmodule
